// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_DMA  = 1'b1;

  localparam int DEF_AW      = 32;
  localparam int DEF_DW      = 32;
  localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/mem_rr_arb2.sv
// Two-way round-robin grant: a lone request wins, a tie goes to whoever did not own the port last.
module mem_rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic core_req,
  input  logic dma_req,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_owner
);

  always_comb begin
    grant_valid = core_req | dma_req;
    grant_owner = OWN_CORE;
    if (core_req && dma_req) begin
      grant_owner = (last_owner == OWN_CORE) ? OWN_DMA : OWN_CORE;
    end else if (dma_req) begin
      grant_owner = OWN_DMA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the microcoded core and a DMA/debug master:
// arbitrate, hold the latched command on the bus until ack or watchdog expiry, then pulse ready.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            core_cs,
  input  logic            core_we,
  input  logic [AW-1:0]   core_addr,
  input  logic [DW-1:0]   core_wdata,
  input  logic [DW/8-1:0] core_be,
  output logic [DW-1:0]   core_rdata,
  output logic            core_ready,
  output logic            core_err,
  input  logic            dma_req,
  input  logic            dma_we,
  input  logic [AW-1:0]   dma_addr,
  input  logic [DW-1:0]   dma_wdata,
  input  logic [DW/8-1:0] dma_be,
  output logic [DW-1:0]   dma_rdata,
  output logic            dma_ready,
  output logic            dma_err,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ack,
  output logic            busy
);

  localparam int BW  = DW / 8;
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t             state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_owner_q, last_owner_d;
  logic               cmd_we_q, cmd_we_d;
  logic [AW-1:0]      cmd_addr_q, cmd_addr_d;
  logic [DW-1:0]      cmd_wdata_q, cmd_wdata_d;
  logic [BW-1:0]      cmd_be_q, cmd_be_d;
  logic [WDW-1:0]     wd_cnt_q, wd_cnt_d;
  logic               err_q, err_d;
  // Index 0 is the core channel, index 1 the DMA channel, matching the owner encoding.
  logic [1:0][DW-1:0] rdata_q, rdata_d;

  logic grant_valid;
  logic grant_owner;
  logic wd_expired;

  mem_rr_arb2 u_arb (
    .core_req    (core_cs),
    .dma_req     (dma_req),
    .last_owner  (last_owner_q),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  if (TIMEOUT != 0) begin : g_wd
    assign wd_expired = (wd_cnt_q == WDW'(TIMEOUT - 1));
  end else begin : g_no_wd
    assign wd_expired = 1'b0;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cmd_we_d     = cmd_we_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    cmd_be_d     = cmd_be_q;
    wd_cnt_d     = wd_cnt_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          owner_d     = grant_owner;
          cmd_we_d    = (grant_owner == OWN_DMA) ? dma_we    : core_we;
          cmd_addr_d  = (grant_owner == OWN_DMA) ? dma_addr  : core_addr;
          cmd_wdata_d = (grant_owner == OWN_DMA) ? dma_wdata : core_wdata;
          cmd_be_d    = (grant_owner == OWN_DMA) ? dma_be    : core_be;
          wd_cnt_d    = '0;
          state_d     = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        // An ack arriving on the expiry cycle still completes normally.
        if (mem_ack) begin
          err_d   = 1'b0;
          state_d = ST_RESP;
          if (!cmd_we_q) begin
            rdata_d[owner_q] = mem_rdata;
          end
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
          if (!cmd_we_q) begin
            rdata_d[owner_q] = '0;
          end
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        last_owner_d = owner_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_CORE;
      last_owner_q <= OWN_DMA;
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      cmd_be_q     <= '0;
      wd_cnt_q     <= '0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cmd_we_q     <= cmd_we_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      cmd_be_q     <= cmd_be_d;
      wd_cnt_q     <= wd_cnt_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  logic [1:0] resp_ready;
  logic [1:0] resp_err;

  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    assign resp_ready[gi] = (state_q == ST_RESP) && (owner_q == 1'(gi));
    assign resp_err[gi]   = resp_ready[gi] & err_q;
  end

  assign core_ready = resp_ready[0];
  assign core_err   = resp_err[0];
  assign core_rdata = rdata_q[0];
  assign dma_ready  = resp_ready[1];
  assign dma_err    = resp_err[1];
  assign dma_rdata  = rdata_q[1];

  assign mem_en    = (state_q == ST_ACTIVE);
  assign mem_we    = mem_en & cmd_we_q;
  assign mem_addr  = cmd_addr_q;
  assign mem_wdata = cmd_wdata_q;
  assign mem_be    = cmd_be_q;
  assign busy      = (state_q == ST_ACTIVE) || (state_q == ST_RESP);

endmodule
